// File: rtl/dna_pkg.sv
// dna_pkg: shared DNA symbol type, base constants and default frame reference.
package dna_pkg;
  typedef logic [1:0] sym_t;
  localparam sym_t SYM_A = 2'd0;
  localparam sym_t SYM_C = 2'd1;
  localparam sym_t SYM_G = 2'd2;
  localparam sym_t SYM_T = 2'd3;
  localparam sym_t DEFAULT_INIT_REF = SYM_A;
endpackage

// File: rtl/diff_word_core.sv
// diff_word_core: combinational differential encode/decode of one N-symbol word.
module diff_word_core
  import dna_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2*N-1:0] i_word,
  input  sym_t           i_ref,
  input  logic           i_mode,
  output logic [2*N-1:0] o_word,
  output sym_t           o_ref
);
  always_comb begin
    sym_t w_prev, w_x, w_y;
    w_prev = i_ref;
    w_x    = '0;
    w_y    = '0;
    o_word = '0;
    for (int k = 0; k < N; k++) begin
      w_x = i_word[2*N-1-2*k -: 2];
      w_y = i_mode ? sym_t'(w_x + w_prev) : sym_t'(w_x - w_prev);
      o_word[2*N-1-2*k -: 2] = w_y;
      // the chained reference is always the plain-domain symbol
      w_prev = i_mode ? w_y : w_x;
    end
    o_ref = w_prev;
  end
endmodule

// File: rtl/differential_stream.sv
// differential_stream: valid/ready streaming differential DNA codec with a single output register.
module differential_stream
  import dna_pkg::*;
#(
  parameter int   N        = 8,
  parameter sym_t INIT_REF = DEFAULT_INIT_REF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_word,
  input  logic           in_sof,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_word,
  output logic           out_last
);
  sym_t           r_ref;
  sym_t           w_ref;
  sym_t           w_next_ref;
  logic [2*N-1:0] w_res;
  logic           w_acc;
  assign in_ready = !out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_ref    = in_sof ? INIT_REF : r_ref;
  diff_word_core #(.N(N)) u_core (
    .i_word (in_word),
    .i_ref  (w_ref),
    .i_mode (mode),
    .o_word (w_res),
    .o_ref  (w_next_ref)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      r_ref     <= INIT_REF;
    end else if (w_acc) begin
      out_valid <= 1'b1;
      out_word  <= w_res;
      out_last  <= in_last;
      r_ref     <= in_last ? INIT_REF : w_next_ref;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_differential_stream.sv
// tb_differential_stream: directed self-checking bench for differential_stream.
module tb_differential_stream;
  localparam int N = 8;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           mode = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] in_word = '0;
  logic           in_sof = 1'b0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] out_word;
  logic           out_last;
  int checks = 0;
  int failures = 0;

  differential_stream #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_sof    (in_sof),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic s, input logic l, input logic [15:0] w);
    mode = m; in_sof = s; in_last = l; in_word = w; in_valid = 1'b1;
  endtask

  task automatic xfer(input string tag, input logic m, input logic s, input logic l,
                      input logic [15:0] w, input logic [15:0] exp);
    drive(m, s, l, w);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_word"}, out_word, exp);
    chk({tag, "_last"}, out_last, l);
  endtask

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);
    // basic encode, chained reference
    xfer("enc_bc18", 0, 1, 0, 16'hBC18, 16'h9116);
    xfer("enc_3939", 0, 1, 0, 16'h3939, 16'h3FFF);
    xfer("enc_chain", 0, 0, 0, 16'hBC18, 16'h5116);
    // decode, then switch back to encode without flushing
    xfer("dec_9116", 1, 1, 0, 16'h9116, 16'hBC18);
    xfer("dec_3fff", 1, 1, 0, 16'h3FFF, 16'h3939);
    xfer("dec_chain", 1, 0, 0, 16'h5116, 16'hBC18);
    xfer("mode_swap", 0, 0, 0, 16'hBC18, 16'h9116);
    // last word resets the reference
    xfer("last_3939", 0, 1, 1, 16'h3939, 16'h3FFF);
    xfer("after_last", 0, 0, 0, 16'hBC18, 16'h9116);
    xfer("single_word", 0, 1, 1, 16'h3939, 16'h3FFF);
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 0);
    // backpressure: first word held, second waits
    out_ready = 1'b0;
    drive(0, 1, 0, 16'h3939);
    @(posedge clk); #1;
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_word", out_word, 16'h3FFF);
    chk("bp_ready_low", in_ready, 0);
    drive(0, 0, 0, 16'hBC18);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_word", out_word, 16'h3FFF);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_word", out_word, 16'h5116);
    @(posedge clk); #1;
    chk("bp_no_dup", out_valid, 0);
    // reset mid-stream discards output and restores INIT_REF
    xfer("pre_rst", 0, 1, 0, 16'h3939, 16'h3FFF);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_word", out_word, 0);
    chk("async_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer("post_rst", 0, 0, 0, 16'hBC18, 16'h9116);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
